// File: rtl/tile_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tile_pass_scheduler
// Purpose  : Walks one layer's tile loop nest (n outermost, then oc, ic
//            innermost). For every tile it issues one pass_start pulse to
//            token_engine, presents that pass's GLB base addresses and real
//            tile sizes, and waits for pass_done before moving on.
//            The first IC tile of every (n, oc) group takes bias; later IC
//            tiles accumulate onto the ipsum already in the opsum buffer.
// Ports    :
//   clk, rst                    clock, synchronous active-high reset
//   layer_start_i               pulse: latch configuration, begin the layer
//   layer_done_o                pulse: the last pass of the layer completed
//   busy_o                      high from the cycle after start through DONE
//   *_tiles_i                   tile counts per loop level
//   tile_*/last_*               full and final tile sizes per level
//   *_base_i, *_stride_i        GLB layer bases and per-tile strides
//   pass_start_o / pass_done_i  handshake with token_engine
//   *_addr_o                    per-pass GLB base addresses
//   is_bias_o                   pass starts from bias (ic index is zero)
//   tile_n_o                    current n index, zero-extended
//   On_real_o/OC_real_o/IC_real_o  real sizes of the current tile
// Revision : 1.0  initial release
// ============================================================================
module tile_pass_scheduler #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              layer_start_i,
  output logic              layer_done_o,
  output logic              busy_o,

  input  logic [CNT_W-1:0]  n_tiles_i,
  input  logic [CNT_W-1:0]  oc_tiles_i,
  input  logic [CNT_W-1:0]  ic_tiles_i,
  input  logic [CNT_W-1:0]  tile_n_rows_i,
  input  logic [CNT_W-1:0]  last_n_rows_i,
  input  logic [CNT_W-1:0]  tile_oc_i,
  input  logic [CNT_W-1:0]  last_oc_i,
  input  logic [CNT_W-1:0]  tile_ic_i,
  input  logic [CNT_W-1:0]  last_ic_i,

  input  logic [ADDR_W-1:0] weight_base_i,
  input  logic [ADDR_W-1:0] ifmap_base_i,
  input  logic [ADDR_W-1:0] opsum_base_i,
  input  logic [ADDR_W-1:0] bias_base_i,
  input  logic [ADDR_W-1:0] weight_tile_stride_i,
  input  logic [ADDR_W-1:0] ifmap_n_stride_i,
  input  logic [ADDR_W-1:0] ifmap_ic_stride_i,
  input  logic [ADDR_W-1:0] ofmap_n_stride_i,
  input  logic [ADDR_W-1:0] ofmap_oc_stride_i,
  input  logic [ADDR_W-1:0] bias_oc_stride_i,

  output logic              pass_start_o,
  input  logic              pass_done_i,

  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] ipsum_addr_o,
  output logic [ADDR_W-1:0] bias_addr_o,
  output logic [ADDR_W-1:0] opsum_addr_o,
  output logic              is_bias_o,
  output logic [31:0]       tile_n_o,
  output logic [31:0]       On_real_o,
  output logic [CNT_W-1:0]  OC_real_o,
  output logic [CNT_W-1:0]  IC_real_o
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;

  // Latched layer configuration
  logic [CNT_W-1:0]  r_n_tiles, r_oc_tiles, r_ic_tiles;
  logic [CNT_W-1:0]  r_tile_n_rows, r_last_n_rows;
  logic [CNT_W-1:0]  r_tile_oc, r_last_oc, r_tile_ic, r_last_ic;
  logic [ADDR_W-1:0] r_weight_base, r_ifmap_base, r_opsum_base, r_bias_base;
  logic [ADDR_W-1:0] r_wt_stride, r_if_n_stride, r_if_ic_stride;
  logic [ADDR_W-1:0] r_of_n_stride, r_of_oc_stride, r_bias_stride;

  // Loop indices
  logic [CNT_W-1:0]  r_n, r_oc, r_ic;

  // Row accumulators: base + n*n_stride, the point each inner sweep restarts from
  logic [ADDR_W-1:0] r_if_row, r_op_row;

  // Registered pass outputs
  logic [ADDR_W-1:0] r_wt_addr, r_if_addr, r_op_addr, r_bias_addr;
  logic              r_is_bias;
  logic [CNT_W-1:0]  r_on_real, r_oc_real, r_ic_real;
  logic              r_pass_start, r_layer_done, r_busy;

  // Loop-advance decode
  logic              w_ic_last, w_oc_last, w_n_last, w_all_last, w_oc_wrap;
  logic              w_any_zero;
  logic [CNT_W-1:0]  w_n_nxt, w_oc_nxt, w_ic_nxt;
  logic [ADDR_W-1:0] w_if_row_nxt, w_op_row_nxt;
  logic [ADDR_W-1:0] w_wt_nxt, w_if_nxt, w_op_nxt, w_bias_nxt;
  logic [CNT_W-1:0]  w_on_nxt, w_oc_real_nxt, w_ic_real_nxt;

  assign w_ic_last  = (r_ic == r_ic_tiles - c_CNT_ONE);
  assign w_oc_last  = (r_oc == r_oc_tiles - c_CNT_ONE);
  assign w_n_last   = (r_n  == r_n_tiles  - c_CNT_ONE);
  assign w_all_last = w_ic_last & w_oc_last & w_n_last;
  assign w_oc_wrap  = w_ic_last & w_oc_last;   // inner two loops finished: n advances
  assign w_any_zero = (r_n_tiles == '0) | (r_oc_tiles == '0) | (r_ic_tiles == '0);

  assign w_ic_nxt = w_ic_last ? '0 : r_ic + c_CNT_ONE;
  assign w_oc_nxt = w_ic_last ? (w_oc_last ? '0 : r_oc + c_CNT_ONE) : r_oc;
  assign w_n_nxt  = w_oc_wrap ? (w_n_last ? '0 : r_n + c_CNT_ONE) : r_n;

  assign w_if_row_nxt = w_oc_wrap ? r_if_row + r_if_n_stride : r_if_row;
  assign w_op_row_nxt = w_oc_wrap ? r_op_row + r_of_n_stride : r_op_row;

  // Weight tiles are laid out (oc, ic)-major, so they step linearly through
  // one n iteration and restart at the base when n advances.
  assign w_wt_nxt   = w_oc_wrap ? r_weight_base : r_wt_addr + r_wt_stride;
  assign w_if_nxt   = w_ic_last ? w_if_row_nxt : r_if_addr + r_if_ic_stride;
  assign w_op_nxt   = w_ic_last ? (w_oc_last ? w_op_row_nxt : r_op_addr + r_of_oc_stride)
                                : r_op_addr;
  assign w_bias_nxt = w_ic_last ? (w_oc_last ? r_bias_base : r_bias_addr + r_bias_stride)
                                : r_bias_addr;

  assign w_on_nxt      = (w_n_nxt  == r_n_tiles  - c_CNT_ONE) ? r_last_n_rows : r_tile_n_rows;
  assign w_oc_real_nxt = (w_oc_nxt == r_oc_tiles - c_CNT_ONE) ? r_last_oc     : r_tile_oc;
  assign w_ic_real_nxt = (w_ic_nxt == r_ic_tiles - c_CNT_ONE) ? r_last_ic     : r_tile_ic;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_n_tiles      <= '0;
      r_oc_tiles     <= '0;
      r_ic_tiles     <= '0;
      r_tile_n_rows  <= '0;
      r_last_n_rows  <= '0;
      r_tile_oc      <= '0;
      r_last_oc      <= '0;
      r_tile_ic      <= '0;
      r_last_ic      <= '0;
      r_weight_base  <= '0;
      r_ifmap_base   <= '0;
      r_opsum_base   <= '0;
      r_bias_base    <= '0;
      r_wt_stride    <= '0;
      r_if_n_stride  <= '0;
      r_if_ic_stride <= '0;
      r_of_n_stride  <= '0;
      r_of_oc_stride <= '0;
      r_bias_stride  <= '0;
      r_n            <= '0;
      r_oc           <= '0;
      r_ic           <= '0;
      r_if_row       <= '0;
      r_op_row       <= '0;
      r_wt_addr      <= '0;
      r_if_addr      <= '0;
      r_op_addr      <= '0;
      r_bias_addr    <= '0;
      r_is_bias      <= 1'b0;
      r_on_real      <= '0;
      r_oc_real      <= '0;
      r_ic_real      <= '0;
      r_pass_start   <= 1'b0;
      r_layer_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_pass_start <= 1'b0;
      r_layer_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (layer_start_i) begin
            r_n_tiles      <= n_tiles_i;
            r_oc_tiles     <= oc_tiles_i;
            r_ic_tiles     <= ic_tiles_i;
            r_tile_n_rows  <= tile_n_rows_i;
            r_last_n_rows  <= last_n_rows_i;
            r_tile_oc      <= tile_oc_i;
            r_last_oc      <= last_oc_i;
            r_tile_ic      <= tile_ic_i;
            r_last_ic      <= last_ic_i;
            r_weight_base  <= weight_base_i;
            r_ifmap_base   <= ifmap_base_i;
            r_opsum_base   <= opsum_base_i;
            r_bias_base    <= bias_base_i;
            r_wt_stride    <= weight_tile_stride_i;
            r_if_n_stride  <= ifmap_n_stride_i;
            r_if_ic_stride <= ifmap_ic_stride_i;
            r_of_n_stride  <= ofmap_n_stride_i;
            r_of_oc_stride <= ofmap_oc_stride_i;
            r_bias_stride  <= bias_oc_stride_i;
            r_n            <= '0;
            r_oc           <= '0;
            r_ic           <= '0;
            r_busy         <= 1'b1;
            r_state        <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_any_zero) begin
            r_layer_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            // First pass: every index is zero, so all addresses are the bases.
            r_if_row     <= r_ifmap_base;
            r_op_row     <= r_opsum_base;
            r_wt_addr    <= r_weight_base;
            r_if_addr    <= r_ifmap_base;
            r_op_addr    <= r_opsum_base;
            r_bias_addr  <= r_bias_base;
            r_is_bias    <= 1'b1;
            r_on_real    <= (r_n_tiles  == c_CNT_ONE) ? r_last_n_rows : r_tile_n_rows;
            r_oc_real    <= (r_oc_tiles == c_CNT_ONE) ? r_last_oc     : r_tile_oc;
            r_ic_real    <= (r_ic_tiles == c_CNT_ONE) ? r_last_ic     : r_tile_ic;
            r_pass_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end

        // A pass_done coinciding with ISSUE cannot belong to this pass.
        S_ISSUE: r_state <= S_WAIT;

        S_WAIT: begin
          if (pass_done_i) begin
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (w_all_last) begin
            r_layer_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_n          <= w_n_nxt;
            r_oc         <= w_oc_nxt;
            r_ic         <= w_ic_nxt;
            r_if_row     <= w_if_row_nxt;
            r_op_row     <= w_op_row_nxt;
            r_wt_addr    <= w_wt_nxt;
            r_if_addr    <= w_if_nxt;
            r_op_addr    <= w_op_nxt;
            r_bias_addr  <= w_bias_nxt;
            r_is_bias    <= w_ic_last;   // ic wraps to zero exactly when it was last
            r_on_real    <= w_on_nxt;
            r_oc_real    <= w_oc_real_nxt;
            r_ic_real    <= w_ic_real_nxt;
            r_pass_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign layer_done_o  = r_layer_done;
  assign busy_o        = r_busy;
  assign pass_start_o  = r_pass_start;
  assign weight_addr_o = r_wt_addr;
  assign ifmap_addr_o  = r_if_addr;
  assign opsum_addr_o  = r_op_addr;
  assign ipsum_addr_o  = r_op_addr;
  assign bias_addr_o   = r_bias_addr;
  assign is_bias_o     = r_is_bias;
  assign tile_n_o      = {{(32-CNT_W){1'b0}}, r_n};
  assign On_real_o     = {{(32-CNT_W){1'b0}}, r_on_real};
  assign OC_real_o     = r_oc_real;
  assign IC_real_o     = r_ic_real;

endmodule
`default_nettype wire

// File: tb/tb_tile_pass_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tile_pass_scheduler
// Purpose  : Self-checking bench for tile_pass_scheduler. A loop-nest model
//            lists every expected pass; the driver plays token_engine and
//            sets per-cycle expectations, a negedge process compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_tile_pass_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        layer_start_i = 1'b0, pass_done_i = 1'b0;
  logic [7:0]  n_tiles_i = '0, oc_tiles_i = '0, ic_tiles_i = '0;
  logic [7:0]  tile_n_rows_i = '0, last_n_rows_i = '0, tile_oc_i = '0, last_oc_i = '0;
  logic [7:0]  tile_ic_i = '0, last_ic_i = '0;
  logic [31:0] weight_base_i = '0, ifmap_base_i = '0, opsum_base_i = '0, bias_base_i = '0;
  logic [31:0] weight_tile_stride_i = '0, ifmap_n_stride_i = '0, ifmap_ic_stride_i = '0;
  logic [31:0] ofmap_n_stride_i = '0, ofmap_oc_stride_i = '0, bias_oc_stride_i = '0;

  logic        layer_done_o, busy_o, pass_start_o, is_bias_o;
  logic [31:0] weight_addr_o, ifmap_addr_o, ipsum_addr_o, bias_addr_o, opsum_addr_o;
  logic [31:0] tile_n_o, On_real_o;
  logic [7:0]  OC_real_o, IC_real_o;

  tile_pass_scheduler #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .layer_start_i(layer_start_i), .layer_done_o(layer_done_o), .busy_o(busy_o),
    .n_tiles_i(n_tiles_i), .oc_tiles_i(oc_tiles_i), .ic_tiles_i(ic_tiles_i),
    .tile_n_rows_i(tile_n_rows_i), .last_n_rows_i(last_n_rows_i),
    .tile_oc_i(tile_oc_i), .last_oc_i(last_oc_i), .tile_ic_i(tile_ic_i), .last_ic_i(last_ic_i),
    .weight_base_i(weight_base_i), .ifmap_base_i(ifmap_base_i),
    .opsum_base_i(opsum_base_i), .bias_base_i(bias_base_i),
    .weight_tile_stride_i(weight_tile_stride_i),
    .ifmap_n_stride_i(ifmap_n_stride_i), .ifmap_ic_stride_i(ifmap_ic_stride_i),
    .ofmap_n_stride_i(ofmap_n_stride_i), .ofmap_oc_stride_i(ofmap_oc_stride_i),
    .bias_oc_stride_i(bias_oc_stride_i),
    .pass_start_o(pass_start_o), .pass_done_i(pass_done_i),
    .weight_addr_o(weight_addr_o), .ifmap_addr_o(ifmap_addr_o), .ipsum_addr_o(ipsum_addr_o),
    .bias_addr_o(bias_addr_o), .opsum_addr_o(opsum_addr_o), .is_bias_o(is_bias_o),
    .tile_n_o(tile_n_o), .On_real_o(On_real_o), .OC_real_o(OC_real_o), .IC_real_o(IC_real_o)
  );

  // ---------------- configuration held by the bench ----------------
  logic [7:0]  cfg_nt, cfg_oct, cfg_ict, cfg_tnr, cfg_lnr, cfg_toc, cfg_loc, cfg_tic, cfg_lic;
  logic [31:0] cfg_wb, cfg_ib, cfg_ob, cfg_bb, cfg_ws, cfg_ins, cfg_ics, cfg_ons, cfg_ocs, cfg_bs;

  typedef struct {
    logic [31:0] w, ifm, op, b, n, on;
    logic        bias;
    logic [7:0]  ocr, icr;
  } pass_t;

  pass_t exp_q[$];
  pass_t exp_cur;

  bit exp_en = 0, exp_zero = 0, exp_chk = 0, exp_ps = 0, exp_ld = 0, exp_busy = 0;
  int checks = 0, failures = 0;
  int ps_count = 0;

  logic [31:0] log_w[$], log_if[$], log_op[$], log_b[$], log_on[$], log_n[$];
  logic        log_bias[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected pass list straight from the address/size formulas.
  task automatic build_model();
    pass_t p;
    logic [31:0] n32, oc32, ic32, ict32;
    exp_q.delete();
    ict32 = {24'd0, cfg_ict};
    for (int n = 0; n < int'(cfg_nt); n++)
      for (int oc = 0; oc < int'(cfg_oct); oc++)
        for (int ic = 0; ic < int'(cfg_ict); ic++) begin
          n32 = n; oc32 = oc; ic32 = ic;
          p.w    = cfg_wb + (oc32 * ict32 + ic32) * cfg_ws;
          p.ifm  = cfg_ib + n32 * cfg_ins + ic32 * cfg_ics;
          p.op   = cfg_ob + n32 * cfg_ons + oc32 * cfg_ocs;
          p.b    = cfg_bb + oc32 * cfg_bs;
          p.n    = n32;
          p.bias = (ic == 0);
          p.on   = (n  == int'(cfg_nt)  - 1) ? {24'd0, cfg_lnr} : {24'd0, cfg_tnr};
          p.ocr  = (oc == int'(cfg_oct) - 1) ? cfg_loc : cfg_toc;
          p.icr  = (ic == int'(cfg_ict) - 1) ? cfg_lic : cfg_tic;
          exp_q.push_back(p);
        end
  endtask

  task automatic apply_cfg();
    n_tiles_i = cfg_nt; oc_tiles_i = cfg_oct; ic_tiles_i = cfg_ict;
    tile_n_rows_i = cfg_tnr; last_n_rows_i = cfg_lnr;
    tile_oc_i = cfg_toc; last_oc_i = cfg_loc; tile_ic_i = cfg_tic; last_ic_i = cfg_lic;
    weight_base_i = cfg_wb; ifmap_base_i = cfg_ib; opsum_base_i = cfg_ob; bias_base_i = cfg_bb;
    weight_tile_stride_i = cfg_ws; ifmap_n_stride_i = cfg_ins; ifmap_ic_stride_i = cfg_ics;
    ofmap_n_stride_i = cfg_ons; ofmap_oc_stride_i = cfg_ocs; bias_oc_stride_i = cfg_bs;
  endtask

  // Garbage on the config pins once the layer is latched.
  task automatic scramble();
    n_tiles_i = 8'($urandom); oc_tiles_i = 8'($urandom); ic_tiles_i = 8'($urandom);
    tile_n_rows_i = 8'($urandom); last_n_rows_i = 8'($urandom);
    tile_oc_i = 8'($urandom); last_oc_i = 8'($urandom);
    tile_ic_i = 8'($urandom); last_ic_i = 8'($urandom);
    weight_base_i = $urandom; ifmap_base_i = $urandom; opsum_base_i = $urandom;
    bias_base_i = $urandom; weight_tile_stride_i = $urandom; ifmap_n_stride_i = $urandom;
    ifmap_ic_stride_i = $urandom; ofmap_n_stride_i = $urandom;
    ofmap_oc_stride_i = $urandom; bias_oc_stride_i = $urandom;
  endtask

  task automatic rand_cfg();
    cfg_nt  = 8'($urandom_range(0, 3)); cfg_oct = 8'($urandom_range(1, 3));
    cfg_ict = 8'($urandom_range(1, 3));
    if ($urandom_range(0, 5) == 0) cfg_nt = 8'd0;
    else if (cfg_nt == 8'd0) cfg_nt = 8'd1;
    cfg_tnr = 8'($urandom); cfg_lnr = 8'($urandom); cfg_toc = 8'($urandom);
    cfg_loc = 8'($urandom); cfg_tic = 8'($urandom); cfg_lic = 8'($urandom);
    cfg_wb = $urandom; cfg_ib = $urandom; cfg_ob = $urandom; cfg_bb = $urandom;
    cfg_ws = $urandom; cfg_ins = $urandom; cfg_ics = $urandom;
    cfg_ons = $urandom; cfg_ocs = $urandom; cfg_bs = $urandom;
  endtask

  task automatic zero_cfg();
    cfg_nt = 0; cfg_oct = 0; cfg_ict = 0; cfg_tnr = 0; cfg_lnr = 0; cfg_toc = 0;
    cfg_loc = 0; cfg_tic = 0; cfg_lic = 0; cfg_wb = 0; cfg_ib = 0; cfg_ob = 0; cfg_bb = 0;
    cfg_ws = 0; cfg_ins = 0; cfg_ics = 0; cfg_ons = 0; cfg_ocs = 0; cfg_bs = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One layer. fixed_d > 0 fixes the start-to-done distance of every pass;
  // abort_at >= 0 asserts rst in the WAIT of that pass and abandons the layer.
  task automatic run_layer(input int fixed_d, input int abort_at);
    int np, d;
    build_model();
    np = exp_q.size();
    log_w.delete(); log_if.delete(); log_op.delete(); log_b.delete();
    log_on.delete(); log_n.delete(); log_bias.delete();
    apply_cfg();
    // IDLE: start, with a stray pass_done
    step(); layer_start_i = 1'b1; pass_done_i = 1'($urandom_range(0, 1));
    exp_ps = 0; exp_ld = 0; exp_busy = 0; exp_chk = 0;
    // CHECK
    step(); layer_start_i = 1'b0; pass_done_i = 1'b0; scramble(); exp_busy = 1;
    for (int p = 0; p < np; p++) begin
      // ISSUE
      step(); exp_ps = 1; exp_chk = 1; exp_cur = exp_q[p];
      pass_done_i = 1'($urandom_range(0, 1)); layer_start_i = 1'($urandom_range(0, 1));
      log_w.push_back(weight_addr_o); log_if.push_back(ifmap_addr_o);
      log_op.push_back(opsum_addr_o); log_b.push_back(bias_addr_o);
      log_on.push_back(On_real_o); log_n.push_back(tile_n_o); log_bias.push_back(is_bias_o);
      if (p == abort_at) begin
        step(); exp_ps = 0; rst = 1'b1; pass_done_i = 1'b0; layer_start_i = 1'b0;
        step(); rst = 1'b0; exp_zero = 1;
        step(); exp_zero = 1;
        step(); exp_zero = 0; exp_chk = 0; exp_ps = 0; exp_ld = 0; exp_busy = 0;
        return;
      end
      d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 6));
      for (int k = 0; k < d; k++) begin
        // WAIT
        step(); exp_ps = 0; layer_start_i = 1'($urandom_range(0, 1));
        pass_done_i = (k == d - 1);
      end
      // NEXT
      step(); exp_chk = 0; pass_done_i = 1'($urandom_range(0, 1));
    end
    // DONE
    step(); exp_ld = 1; exp_busy = 1; layer_start_i = 1'($urandom_range(0, 1));
    pass_done_i = 1'($urandom_range(0, 1));
    // IDLE
    step(); exp_ld = 0; exp_busy = 0; layer_start_i = 1'b0; pass_done_i = 1'b0;
    step();
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (pass_start_o === 1'b1) ps_count++;
    if (exp_en) begin
      if (exp_zero) begin
        chk("rst_pass_start", {31'd0, pass_start_o}, 32'd0);
        chk("rst_layer_done", {31'd0, layer_done_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_weight", weight_addr_o, 32'd0);
        chk("rst_ifmap", ifmap_addr_o, 32'd0);
        chk("rst_opsum", opsum_addr_o, 32'd0);
        chk("rst_ipsum", ipsum_addr_o, 32'd0);
        chk("rst_bias_addr", bias_addr_o, 32'd0);
        chk("rst_is_bias", {31'd0, is_bias_o}, 32'd0);
        chk("rst_tile_n", tile_n_o, 32'd0);
        chk("rst_on_real", On_real_o, 32'd0);
        chk("rst_oc_real", {24'd0, OC_real_o}, 32'd0);
        chk("rst_ic_real", {24'd0, IC_real_o}, 32'd0);
      end else begin
        chk("pass_start", {31'd0, pass_start_o}, {31'd0, exp_ps});
        chk("layer_done", {31'd0, layer_done_o}, {31'd0, exp_ld});
        chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
        if (exp_chk) begin
          chk("weight_addr", weight_addr_o, exp_cur.w);
          chk("ifmap_addr", ifmap_addr_o, exp_cur.ifm);
          chk("opsum_addr", opsum_addr_o, exp_cur.op);
          chk("ipsum_addr", ipsum_addr_o, exp_cur.op);
          chk("bias_addr", bias_addr_o, exp_cur.b);
          chk("is_bias", {31'd0, is_bias_o}, {31'd0, exp_cur.bias});
          chk("tile_n", tile_n_o, exp_cur.n);
          chk("On_real", On_real_o, exp_cur.on);
          chk("OC_real", {24'd0, OC_real_o}, {24'd0, exp_cur.ocr});
          chk("IC_real", {24'd0, IC_real_o}, {24'd0, exp_cur.icr});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ps0;
    rst = 1'b1;
    step(); step();
    exp_en = 1; exp_zero = 1;
    step(); rst = 1'b0;
    step(); exp_zero = 0; exp_busy = 0; exp_ps = 0; exp_ld = 0;

    // Single-tile layer
    zero_cfg();
    cfg_nt = 1; cfg_oct = 1; cfg_ict = 1;
    cfg_tnr = 8'd9; cfg_lnr = 8'd5; cfg_toc = 8'd9; cfg_loc = 8'd7; cfg_tic = 8'd9; cfg_lic = 8'd3;
    cfg_wb = 32'h100; cfg_ib = 32'h200; cfg_ob = 32'h300; cfg_bb = 32'h400;
    cfg_ws = 32'h40; cfg_ics = 32'h10; cfg_ocs = 32'h20;
    ps0 = ps_count;
    run_layer(10, -1);
    chk("t1_pass_count", ps_count - ps0, 32'd1);
    chk("t1_is_bias", {31'd0, log_bias[0]}, 32'd1);
    chk("t1_weight", log_w[0], 32'h100);
    chk("t1_ifmap", log_if[0], 32'h200);
    chk("t1_opsum", log_op[0], 32'h300);
    chk("t1_bias_addr", log_b[0], 32'h400);
    chk("t1_on_real", log_on[0], 32'd5);

    // 2x2x3 nest
    zero_cfg();
    cfg_nt = 2; cfg_oct = 2; cfg_ict = 3;
    cfg_ws = 32'h40; cfg_ics = 32'h10; cfg_ocs = 32'h20; cfg_ons = 32'h1000; cfg_bs = 32'h4;
    ps0 = ps_count;
    run_layer(0, -1);
    chk("t2_pass_count", ps_count - ps0, 32'd12);
    chk("t2_weight5", log_w[5], 32'h140);
    chk("t2_weight6", log_w[6], 32'h0);
    chk("t2_bias3", {31'd0, log_bias[3]}, 32'd1);
    chk("t2_bias4", {31'd0, log_bias[4]}, 32'd0);
    chk("t2_opsum3", log_op[3], 32'h20);
    chk("t2_opsum5", log_op[5], 32'h20);
    chk("t2_opsum6", log_op[6], 32'h1000);
    chk("t2_ifmap2", log_if[2], 32'h20);

    // Partial n tiles
    zero_cfg();
    cfg_nt = 3; cfg_oct = 1; cfg_ict = 1; cfg_tnr = 8'd8; cfg_lnr = 8'd2;
    run_layer(0, -1);
    chk("t3_on0", log_on[0], 32'd8);
    chk("t3_on1", log_on[1], 32'd8);
    chk("t3_on2", log_on[2], 32'd2);

    // Zero OC count
    zero_cfg();
    cfg_nt = 2; cfg_oct = 0; cfg_ict = 2;
    ps0 = ps_count;
    run_layer(0, -1);
    chk("t4_pass_count", ps_count - ps0, 32'd0);

    // Reset in WAIT of pass 4, then a clean restart
    zero_cfg();
    cfg_nt = 2; cfg_oct = 2; cfg_ict = 3;
    cfg_ws = 32'h40; cfg_ics = 32'h10; cfg_ocs = 32'h20; cfg_ons = 32'h1000;
    run_layer(0, 3);
    ps0 = ps_count;
    run_layer(0, -1);
    chk("t5_pass_count", ps_count - ps0, 32'd12);
    chk("t5_first_bias", {31'd0, log_bias[0]}, 32'd1);
    chk("t5_first_n", log_n[0], 32'd0);
    chk("t5_first_weight", log_w[0], 32'd0);

    // Randomized layers
    for (int t = 0; t < 12; t++) begin
      rand_cfg();
      run_layer(0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
